multi_debounce: RTL and testbench
=================================

# multi_debounce

Parametrised N-channel switch/button debouncer. Each channel gets a configurable-depth synchroniser, a stability counter with a runtime-programmable threshold, and a registered clean level with single-cycle rise and fall event pulses. An optional long-press detector is compiled in by macro. The block sits between raw board-level inputs (keys, DIP switches, encoders) and the synchronous control logic. It replaces the single-channel fixed-threshold debouncer.

## Interface
- `N`, default 4: number of independent channels, at least 1.
- `CNT_W`, default 4: stability counter width; maximum threshold is 2^CNT_W−1.
- `SYNC_STAGES`, default 2: synchroniser depth, from 2 to 4.
- `LONG_W`, default 5: long-press counter width. Used only with the macro.
- `clock`, input, 1: single clock; every flop is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `raw_in`, input, N: asynchronous raw inputs, one bit per channel.
- `thresh`, input, CNT_W: stability threshold shared by all channels. It is quasi-static and sampled every cycle.
- `clean_out`, output, N: debounced level, registered.
- `rise_pulse`, output, N: one-cycle strobe on a clean 0→1 transition.
- `fall_pulse`, output, N: one-cycle strobe on a clean 1→0 transition.
- `any_event`, output, 1: registered OR of all rise and fall strobes, in the same cycle as those strobes.
- `long_pulse`, output, N: one-cycle long-press strobe. Tied to 0 when the macro is off.

## Operation
- On `reset` low, every flop clears immediately, without waiting for a clock edge. This covers sync chains, candidate, counters, all outputs and long counters.
- Per channel i, the synchroniser shifts `raw_in[i]` through SYNC_STAGES flops. Only `sync_out` (the last stage) is used downstream.
- Each channel holds a candidate register `cand` and a counter `cnt` (CNT_W bits). At each edge:
  - If `sync_out != cand`: load `cand <= sync_out` and `cnt <= 0`.
  - Otherwise, if `cnt >= thresh` and `cand != clean_out[i]`: update `clean_out[i] <= cand` and raise the matching rise or fall pulse.
  - Otherwise, if `cnt < thresh`: `cnt <= cnt + 1`.
- `cnt` saturates at `thresh` and never wraps. The `>=` comparison makes a threshold lowered mid-count take effect on the next edge.
- Threshold 0: the commit happens on the first edge after `cand` settles.
- Pulses are registered and asserted for exactly one cycle. They are never asserted while `clean_out` is unchanged.
- Channels are fully independent. Simultaneous events on several channels all appear in the same cycle.
- Any change of `sync_out` mid-count restarts that channel's count from 0. The outputs keep their old value.

## Timing
- SYNC_STAGES=S. The new raw level is first sampled at edge E0 and stays stable.
- `cand` updates at E0+S.
- `clean_out` and the pulse update at E0+S+thresh+1. With defaults and thresh=7, that is 10 edges.
- A raw level held for L consecutive samples commits only if L ≥ thresh+2. Shorter glitches never reach `clean_out`.
- After reset is released, the first raw sample is taken on the first rising edge. Outputs stay 0 until a full qualification completes.

## Configuration
- `MULTI_DEBOUNCE_LONGPRESS_EN` defined: each channel gets a LONG_W-bit counter.
  - The counter clears when `clean_out[i]` is 0 and on the rise edge.
  - It increments each cycle while the channel is high, saturating at all-ones.
  - `long_pulse[i]` fires once, 2^LONG_W−1 edges after `rise_pulse[i]` (31 with defaults).
  - No repeat occurs until a release and a fresh press.
- Not defined: no long-press logic is generated and `long_pulse` is driven constant 0.

## Test plan
Defaults throughout: N=4, CNT_W=4, S=2, thresh=7.
- Clean step: `raw_in[0]` goes 0→1 and holds. `clean_out[0]` rises exactly 10 edges later, with `rise_pulse[0]` and `any_event` high for one cycle. Other channels show no activity.
- Bounce: `raw_in[1]` toggles every 3 cycles for 30 cycles, then holds 1. There is no output change during the bounce, then a single rise 10 edges after the final edge.
- Glitch width: an 8-sample high pulse on channel 2 leaves `clean_out[2]` at 0. A 9-sample pulse produces a rise followed by a fall, one pulse each.
- Runtime threshold: with thresh=0, a step commits in 3 edges. Lowering thresh from 7 to 2 while `cnt` is 5 commits on the next edge.
- Async reset: assert `reset` low, with no clock, while `clean_out`=4'b1111. All outputs go to 0 immediately. After release with raw still all-ones, all four channels rise together 10 edges later, and `any_event` asserts once.
- Long press, with the macro: hold channel 3 for 40 cycles. `long_pulse[3]` fires once, 31 edges after `rise_pulse[3]`. Release and re-press gives a second `long_pulse`. Without the macro, `long_pulse` stays 0.

Source files
------------

// File: rtl/multi_debounce.sv
// multi_debounce: N-channel switch/button debouncer.
// Each channel has a SYNC_STAGES-deep synchroniser, a candidate level with a
// stability counter compared against a shared runtime threshold, and a
// registered clean level with one-cycle rise/fall strobes.
// Optional long-press detector: define MULTI_DEBOUNCE_LONGPRESS_EN.
module multi_debounce #(
   parameter int N           = 4,
   parameter int CNT_W       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int LONG_W      = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N-1:0]     raw_in,
   input  logic [CNT_W-1:0] thresh,
   output logic [N-1:0]     clean_out,
   output logic [N-1:0]     rise_pulse,
   output logic [N-1:0]     fall_pulse,
   output logic             any_event,
   output logic [N-1:0]     long_pulse
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q [N];
   logic [CNT_W-1:0]       cnt    [N];
   logic [N-1:0]           sync_out;
   logic [N-1:0]           cand;
   logic [N-1:0]           restart;
   logic [N-1:0]           commit;
   logic [N-1:0]           count_up;
   logic [N-1:0]           rise_next;
   logic [N-1:0]           fall_next;

   for (genvar g = 0; g < N; g++) begin : g_sync_tap
      assign sync_out[g] = sync_q[g][SYNC_STAGES-1];
   end

   // Shift each raw input through its own synchroniser chain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
         end
      end
   end

   // Per channel: restart on a new synchronised level, commit once stable long enough, otherwise count.
   always_comb begin
      restart  = '0;
      commit   = '0;
      count_up = '0;
      for (int i = 0; i < N; i++) begin
         restart[i]  = (sync_out[i] != cand[i]);
         commit[i]   = !restart[i] && (cnt[i] >= thresh) && (cand[i] != clean_out[i]);
         count_up[i] = !restart[i] && !commit[i] && (cnt[i] < thresh);
      end
   end

   assign rise_next = commit & cand;
   assign fall_next = commit & ~cand;

   // Candidate/counter update, clean level commit and registered event strobes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cand       <= '0;
         clean_out  <= '0;
         rise_pulse <= '0;
         fall_pulse <= '0;
         any_event  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (restart[i]) begin
               cand[i] <= sync_out[i];
               cnt[i]  <= '0;
            end else if (commit[i]) begin
               clean_out[i] <= cand[i];
            end else if (count_up[i]) begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
         rise_pulse <= rise_next;
         fall_pulse <= fall_next;
         any_event  <= |(rise_next | fall_next);
      end
   end

`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
   localparam logic [LONG_W-1:0] LONG_MAX  = {LONG_W{1'b1}};
   localparam logic [LONG_W-1:0] LONG_FIRE = LONG_MAX - LONG_W'(1);

   logic [LONG_W-1:0] long_cnt [N];

   // Count cycles spent high since the rise; fire once as the counter reaches all-ones.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         long_pulse <= '0;
         for (int i = 0; i < N; i++) begin
            long_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            long_pulse[i] <= clean_out[i] && (long_cnt[i] == LONG_FIRE);
            if (!clean_out[i] || rise_next[i]) begin
               long_cnt[i] <= '0;
            end else if (long_cnt[i] != LONG_MAX) begin
               long_cnt[i] <= long_cnt[i] + LONG_W'(1);
            end
         end
      end
   end
`else
   assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: directed and random stimulus for multi_debounce, checked
// against a reference model that tracks how long each synchronised level has
// been stable and when each channel last rose.
module tb_multi_debounce;

   localparam int N      = 4;
   localparam int CNT_W  = 4;
   localparam int S      = 2;
   localparam int LONG_W = 5;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [N-1:0]     raw_in = '0;
   logic [CNT_W-1:0] thresh = CNT_W'(7);
   logic [N-1:0]     clean_out;
   logic [N-1:0]     rise_pulse;
   logic [N-1:0]     fall_pulse;
   logic             any_event;
   logic [N-1:0]     long_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   multi_debounce #(
      .N(N), .CNT_W(CNT_W), .SYNC_STAGES(S), .LONG_W(LONG_W)
   ) dut (
      .clock(clock), .reset(reset), .raw_in(raw_in), .thresh(thresh),
      .clean_out(clean_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .any_event(any_event), .long_pulse(long_pulse)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   // Reference model state.
   logic [N-1:0] samples [$];
   logic [N-1:0] m_seen, m_clean, m_rise, m_fall, m_long;
   int           m_age [N];
   int           rise_edge [N];
   int           edge_no = 0;

   // Event bookkeeping for directed checks.
   int rise_cnt [N];
   int fall_cnt [N];
   int long_cnt [N];
   int long_gap [N];
   int rise_tick [N];
   int any_cnt;
   int tick_no = 0;
   int hit;

   task automatic modelReset();
      samples.delete();
      m_seen = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_long = '0;
      for (int i = 0; i < N; i++) begin
         m_age[i]     = 1;
         rise_edge[i] = -100000;
      end
   endtask

   task automatic modelEdge();
      logic [N-1:0] sync_v;
      logic [N-1:0] prev_clean;
      sync_v = (samples.size() >= S) ? samples[0] : '0;
      samples.push_back(raw_in);
      if (samples.size() > S) void'(samples.pop_front());
      prev_clean = m_clean;
      m_rise = '0; m_fall = '0; m_long = '0;
      for (int i = 0; i < N; i++) begin
`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
         if (prev_clean[i] && (edge_no - rise_edge[i] == (1 << LONG_W) - 1)) m_long[i] = 1'b1;
`endif
         if (sync_v[i] != m_seen[i]) begin
            m_seen[i] = sync_v[i];
            m_age[i]  = 1;
         end else if (m_age[i] < 100000) begin
            m_age[i]++;
         end
         if (m_age[i] >= int'(thresh) + 2 && m_seen[i] != m_clean[i]) begin
            m_clean[i] = m_seen[i];
            if (m_seen[i]) begin
               m_rise[i]    = 1'b1;
               rise_edge[i] = edge_no;
            end else begin
               m_fall[i] = 1'b1;
            end
         end
      end
      edge_no++;
   endtask

   task automatic checkOutput(input string tag);
      n_checks++;
      assert (clean_out === m_clean) else begin
         n_fail++; $error("[TB] FAIL %s clean_out got %b expected %b", tag, clean_out, m_clean);
      end
      n_checks++;
      assert (rise_pulse === m_rise) else begin
         n_fail++; $error("[TB] FAIL %s rise_pulse got %b expected %b", tag, rise_pulse, m_rise);
      end
      n_checks++;
      assert (fall_pulse === m_fall) else begin
         n_fail++; $error("[TB] FAIL %s fall_pulse got %b expected %b", tag, fall_pulse, m_fall);
      end
      n_checks++;
      assert (any_event === |(m_rise | m_fall)) else begin
         n_fail++; $error("[TB] FAIL %s any_event got %b expected %b", tag, any_event, |(m_rise | m_fall));
      end
      n_checks++;
      assert (long_pulse === m_long) else begin
         n_fail++; $error("[TB] FAIL %s long_pulse got %b expected %b", tag, long_pulse, m_long);
      end
   endtask

   task automatic checkValue(input string tag, input int got, input int expected);
      n_checks++;
      assert (got === expected) else begin
         n_fail++; $error("[TB] FAIL %s got %0d expected %0d", tag, got, expected);
      end
   endtask

   task automatic clearCounts();
      for (int i = 0; i < N; i++) begin
         rise_cnt[i] = 0; fall_cnt[i] = 0; long_cnt[i] = 0; long_gap[i] = -1; rise_tick[i] = -100000;
      end
      any_cnt = 0;
   endtask

   task automatic tick(input string tag);
      @(posedge clock);
      if (reset) modelEdge();
      #1;
      checkOutput(tag);
      for (int i = 0; i < N; i++) begin
         if (rise_pulse[i]) begin
            rise_cnt[i]++;
            rise_tick[i] = tick_no;
         end
         if (fall_pulse[i]) fall_cnt[i]++;
         if (long_pulse[i]) begin
            long_cnt[i]++;
            long_gap[i] = tick_no - rise_tick[i];
         end
      end
      if (any_event) any_cnt++;
      tick_no++;
   endtask

   task automatic applyStimulus(input logic [N-1:0] raw, input int cycles, input string tag);
      @(negedge clock);
      raw_in = raw;
      repeat (cycles) tick(tag);
   endtask

   task automatic runWatch(input int ch, input int budget, input string tag, output int first);
      first = -1;
      for (int k = 0; k < budget; k++) begin
         tick(tag);
         if (rise_pulse[ch] && first < 0) first = k;
      end
   endtask

   initial begin
      $display("[TB] multi_debounce test starting");
      modelReset();
      clearCounts();
      repeat (3) tick("in_reset");
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(4'b0000, 5, "idle");

      // Clean step on channel 0.
      clearCounts();
      @(negedge clock);
      raw_in = 4'b0001;
      runWatch(0, 20, "step", hit);
      checkValue("step_latency", hit, 10);
      checkValue("step_rises", rise_cnt[0], 1);
      checkValue("step_others", rise_cnt[1] + rise_cnt[2] + rise_cnt[3] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 0);
      checkValue("step_any", any_cnt, 1);

      // Bounce on channel 1 then hold high.
      clearCounts();
      for (int seg = 0; seg < 10; seg++) begin
         applyStimulus((seg % 2 == 0) ? 4'b0011 : 4'b0001, 3, "bounce");
      end
      checkValue("bounce_quiet", rise_cnt[1] + fall_cnt[1], 0);
      @(negedge clock);
      raw_in = 4'b0011;
      runWatch(1, 20, "bounce_hold", hit);
      checkValue("bounce_latency", hit, 10);
      checkValue("bounce_rises", rise_cnt[1], 1);

      // Glitch widths on channel 2.
      clearCounts();
      applyStimulus(4'b0111, 8, "glitch8");
      applyStimulus(4'b0011, 20, "glitch8_low");
      checkValue("glitch8_events", rise_cnt[2] + fall_cnt[2], 0);
      applyStimulus(4'b0111, 9, "glitch9");
      applyStimulus(4'b0011, 25, "glitch9_low");
      checkValue("glitch9_rises", rise_cnt[2], 1);
      checkValue("glitch9_falls", fall_cnt[2], 1);

      // Threshold zero commits three edges after the step.
      @(negedge clock);
      thresh = '0;
      @(negedge clock);
      raw_in = 4'b0111;
      runWatch(2, 10, "thresh0", hit);
      checkValue("thresh0_latency", hit, 3);
      @(negedge clock);
      thresh = CNT_W'(7);
      applyStimulus(4'b0111, 5, "thresh_restore");

      // Lower the threshold from 7 to 2 once the count has reached 5.
      @(negedge clock);
      raw_in = 4'b1111;
      hit = -1;
      for (int k = 0; k < 8; k++) begin
         tick("lower_pre");
         if (rise_pulse[3] && hit < 0) hit = k;
      end
      @(negedge clock);
      thresh = CNT_W'(2);
      for (int k = 8; k < 20; k++) begin
         tick("lower_post");
         if (rise_pulse[3] && hit < 0) hit = k;
      end
      checkValue("lower_latency", hit, 8);
      @(negedge clock);
      thresh = CNT_W'(7);
      applyStimulus(4'b1111, 5, "full");

      // Asynchronous reset between clock edges.
      #2;
      reset = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset");
      repeat (2) tick("held_reset");
      clearCounts();
      @(negedge clock);
      reset = 1'b1;
      runWatch(0, 20, "post_reset", hit);
      checkValue("post_reset_latency", hit, 10);
      checkValue("post_reset_rises", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 4);
      checkValue("post_reset_any", any_cnt, 1);

      // Long press on channel 3, twice.
      applyStimulus(4'b0000, 15, "long_idle");
      clearCounts();
      applyStimulus(4'b1000, 45, "long_press1");
`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
      checkValue("long_gap", long_gap[3], 31);
`endif
      applyStimulus(4'b0000, 15, "long_release");
      applyStimulus(4'b1000, 45, "long_press2");
`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
      checkValue("long_count", long_cnt[3], 2);
`else
      checkValue("long_count", long_cnt[3], 0);
`endif
      applyStimulus(4'b0000, 20, "long_done");

      // Random activity with a fixed threshold per block.
      for (int blk = 0; blk < 4; blk++) begin
         @(negedge clock);
         thresh = CNT_W'($urandom_range(0, 7));
         for (int c = 0; c < 150; c++) begin
            logic [N-1:0] flip;
            flip = '0;
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 5) == 0);
            applyStimulus(raw_in ^ flip, 1, "random");
         end
         applyStimulus(raw_in, 20, "random_settle");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
